// File: rtl/acc_rr_sched.sv
// Round-robin scheduler that shares one frame accumulator among NUM_REQ requesters.
// Define ACC_SAT_EN to make the accumulator saturate and to add the res_ovf output.
module acc_rr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int ACC_W     = 8,
    parameter int FRAME_LEN = 8,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          res_data,
    output logic [ID_W-1:0]           res_id,
`ifdef ACC_SAT_EN
    output logic                      res_ovf,
`endif
    output logic                      busy
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ID_W-1:0]   grant_reg;
    logic [ID_W-1:0]   last_grant_reg;
    logic              res_valid_reg;

    logic [DATA_W-1:0] sample [NUM_REQ];
    logic [ID_W-1:0]   pick_next;
    logic [ACC_W-1:0]  acc_next;
    logic              beat;

    // Ready depends only on registered state and grant, never on req_valid.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign sample[gi]    = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = (state_reg == ACCUM) && (grant_reg == ID_W'(gi));
        end
    endgenerate

    // Search from last_grant+1 with wrap; descending loop lets the nearest candidate win.
    always_comb begin
        pick_next = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[ID_W'((int'(last_grant_reg) + k) % NUM_REQ)]) begin
                pick_next = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
            end
        end
    end

    assign beat = (state_reg == ACCUM) && req_valid[grant_reg];

`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum_next;
    logic           ovf_reg;
    assign sum_next = {1'b0, acc_reg} + (ACC_W+1)'(sample[grant_reg]);
    assign acc_next = sum_next[ACC_W] ? '1 : sum_next[ACC_W-1:0];
    assign res_ovf  = ovf_reg;
`else
    assign acc_next = acc_reg + ACC_W'(sample[grant_reg]);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            grant_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            res_valid_reg  <= 1'b0;
`ifdef ACC_SAT_EN
            ovf_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        grant_reg <= pick_next;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
`ifdef ACC_SAT_EN
                        ovf_reg   <= 1'b0;
`endif
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
`ifdef ACC_SAT_EN
                        ovf_reg <= ovf_reg | sum_next[ACC_W];
`endif
                        if (cnt_reg == CNT_LAST) begin
                            state_reg     <= RESULT;
                            res_valid_reg <= 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        last_grant_reg <= grant_reg;
                        res_valid_reg  <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = acc_reg;
    assign res_id    = grant_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/acc_rr_sched.md
Name: acc_rr_sched

Overview:
- Round-robin scheduler that shares one accumulator datapath among NUM_REQ requesters.
- Grants one requester per frame, clears the accumulator on grant and sums exactly FRAME_LEN accepted samples.
- Presents the sum, tagged with the requester ID, on a valid/ready result port.
- Sits between the sample producers and the downstream result consumer; it owns both the accumulator sequencing and access to it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, sample width; samples are unsigned and zero-extended before the add.
- ACC_W, 8, accumulator and result width.
- FRAME_LEN, 8, accepted samples per frame (>=1).
- ID_W, $clog2(NUM_REQ), localparam derived from NUM_REQ; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*DATA_W  packed samples; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester sample accept; one-hot or zero.
- res_valid  out  1  frame result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  ACC_W  frame sum.
- res_id  out  ID_W  index of the requester that produced the frame.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at a clock edge) sets:
  - state IDLE; acc 0; cnt 0; grant 0; last_grant NUM_REQ-1.
  - req_ready all 0; res_valid 0; res_data 0; res_id 0; busy 0.
- Reset asserted mid-frame or mid-result discards all partial and pending data. No result is emitted for that frame.
- States: IDLE, ACCUM, RESULT.
- IDLE:
  - req_ready is all 0; no sample is consumed.
  - If any req_valid bit is set, grant the first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap.
  - Registered effects: grant set, acc <= 0, cnt <= 0, state <= ACCUM.
  - Arbitration costs 1 cycle.
- ACCUM:
  - req_ready[grant] = 1; all other req_ready bits = 0.
  - A beat is accepted only when req_valid[grant] && req_ready[grant]. On accept: acc <= acc + zero-extended req_data[grant]; cnt <= cnt + 1.
  - Cycles with req_valid[grant] low are idle cycles. There is no timeout and no re-arbitration mid-frame.
  - Accepting the beat with cnt == FRAME_LEN-1 moves the state to RESULT.
  - req_valid from non-granted requesters is ignored and their data is not sampled.
- RESULT:
  - res_valid = 1; res_data = acc; res_id = grant.
  - Outputs are held stable until res_ready.
  - On res_valid && res_ready: last_grant <= grant, state <= IDLE, res_valid drops on the next cycle.
- Throughput:
  - With res_ready tied high and no valid gaps, one frame completes every FRAME_LEN+2 cycles.
  - res_valid rises on the cycle after the last beat is accepted.
- Arithmetic: the sum wraps modulo 2^ACC_W, unless the optional feature below is compiled in.
- Timing paths:
  - req_ready is decoded from registered state and grant only; there is no combinational path from req_valid to req_ready.
  - res_* are driven from registers.
- Fairness: a requester that holds req_valid continuously is served within NUM_REQ frames.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - The add saturates at 2^ACC_W-1 instead of wrapping.
  - An extra output port res_ovf (1 bit) is present. It is set if any add in the current frame saturated, cleared on grant, and valid alongside res_valid.
  - res_ovf resets to 0.
- Undefined: the add wraps modulo 2^ACC_W and the res_ovf port does not exist.

Test Plan:
- Single requester, no gaps: after reset, requester 0 drives 8 beats of 4'hF -> res_data 0x78, res_id 0; res_valid rises 1 cycle after the 8th accepted beat; next frame is granted 1 cycle after the result handshake.
- Fairness: all 4 requesters hold req_valid high, samples 4'h1 -> grants in order 0,1,2,3,0; each result is 0x08; req_ready is never more than one-hot.
- Backpressure: res_ready held low for 5 cycles in RESULT -> res_data and res_id stay stable, busy=1, req_ready all 0; the handshake occurs on the cycle res_ready rises.
- Valid gaps: granted requester 2 sends 1,2,3,4,5,6,7,8 with 1-cycle gaps between beats -> res_data 0x24, res_id 2; gap cycles do not increment cnt.
- Overflow, FRAME_LEN=32, all samples 4'hF:
  - without ACC_SAT_EN -> res_data 0xE0 (480 mod 256);
  - with ACC_SAT_EN -> res_data 0xFF, res_ovf=1, and the following frame of all 4'h1 gives res_ovf=0.
- Reset mid-frame: rst_n pulsed low after 3 accepted beats from requester 1 -> all outputs return to reset values and no result is emitted; with all requesters valid afterwards, the first grant goes to requester 0.
